// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle stage sequencer for the sequential Y86-64 core. Walks one
// instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD,
// raising exactly one stage enable per cycle. MEMORY is held on a req/ack
// handshake for memory icodes, with a timeout that turns a missing ack into
// an ADR fault. Fetch and data faults are converted into the Y86 status code.
// Cycle and retired-instruction counters saturate at all-ones.
//
// Optional build macro:
//   SEQ_STEP_EN : adds the step input. PCUPD returns to IDLE, so exactly one
//                 instruction runs per step (or start) pulse.
//
// Parameters:
//   MEM_TIMEOUT : max MEMORY cycles waiting for mem_ack (>= 1)
//   CNT_W       : width of cycle_cnt / instr_cnt
//
// Ports:
//   clk, rst_n         : rising-edge clock, async active-low reset
//   start              : leave IDLE or HALT (HALT exit clears stat/counters)
//   step               : (SEQ_STEP_EN only) run one instruction from IDLE
//   icode, instr_valid : fetch results, valid at the end of FETCH
//   imem_error         : instruction address fault during FETCH
//   mem_ack, dmem_error: data memory completion and its fault flag
//   *_en               : one-hot stage enables
//   mem_req            : data memory request
//   stat               : 0=AOK 1=HLT 2=ADR 3=INS
//   busy, halted       : FSM not in IDLE/HALT, FSM in HALT
//   cycle_cnt          : busy cycles
//   instr_cnt          : retired instructions
//
// Handshake: mem_req is high in every MEMORY cycle of a memory icode; the
// access completes in the first cycle where mem_req and mem_ack are both
// high (dmem_error is sampled in that same cycle). mem_ack at any other
// time has no effect.
// ----------------------------------------------------------------------------
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic [1:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_PCUPD     = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Timeout counter runs 0 .. MEM_TIMEOUT-1 while in MEMORY.
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [1:0]       stat_nxt;
    logic [3:0]       icode_q;
    logic [TW-1:0]    tmo_cnt;
    logic             mem_icode;
    logic             clr_cnt;
    logic             retire;
    logic             go;

    // icodes that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
    always_comb begin
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_icode = 1'b1;
            default:                           mem_icode = 1'b0;
        endcase
    end

`ifdef SEQ_STEP_EN
    assign go = start | step;
`else
    assign go = start;
`endif

    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        clr_cnt   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // Fault priority: ADR over INS over HLT
                if (imem_error) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_HLT;
                end else begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE:  state_nxt = S_EXECUTE;
            S_EXECUTE: state_nxt = S_MEMORY;
            S_MEMORY: begin
                if (!mem_icode) begin
                    state_nxt = S_WRITEBACK;
                end else if (mem_ack) begin
                    // ack is checked before timeout so it wins a tie
                    if (dmem_error) begin
                        state_nxt = S_HALT;
                        stat_nxt  = STAT_ADR;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_HALT;
                    stat_nxt  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_nxt = S_PCUPD;
            S_PCUPD: begin
                retire = 1'b1;
`ifdef SEQ_STEP_EN
                state_nxt = S_IDLE;
`else
                state_nxt = S_FETCH;
`endif
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    stat_nxt  = STAT_AOK;
                    clr_cnt   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            stat  <= STAT_AOK;
        end else begin
            state <= state_nxt;
            stat  <= stat_nxt;
        end
    end

    // icode is held for the MEMORY decision made three cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q <= 4'h0;
        end else if (state == S_FETCH) begin
            icode_q <= icode;
        end
    end

    // Cleared in EXECUTE so it reads 0 on the first MEMORY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_EXECUTE) begin
            tmo_cnt <= '0;
        end else if (state == S_MEMORY && tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (clr_cnt) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire && instr_cnt != CNT_MAX) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // All outputs decode directly from the state register
    assign fetch_en   = (state == S_FETCH);
    assign decode_en  = (state == S_DECODE);
    assign execute_en = (state == S_EXECUTE);
    assign memory_en  = (state == S_MEMORY);
    assign wb_en      = (state == S_WRITEBACK);
    assign pc_en      = (state == S_PCUPD);
    assign mem_req    = (state == S_MEMORY) && mem_icode;
    assign halted     = (state == S_HALT);
    assign busy       = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the sequential Y86-64 core. Drives one-hot stage enables (fetch, decode, execute, memory, write-back, PC update) so each stage, including register-file decode, is evaluated in its own cycle. Holds the memory stage on a req/ack handshake, converts fetch and memory faults into the Y86 status code, and keeps cycle and retired-instruction counters. Sits beside the stage modules in the sequential top level.

## Interface

Parameters:
- MEM_TIMEOUT, 15: maximum cycles MEMORY waits for mem_ack before an ADR fault; minimum 1.
- CNT_W, 32: width of cycle_cnt and instr_cnt.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE or HALT.
- icode  in  4  instruction code from fetch, valid at the end of FETCH.
- instr_valid  in  1  fetch decoded a legal icode.
- imem_error  in  1  instruction address fault during FETCH.
- mem_ack  in  1  data memory completes the access.
- dmem_error  in  1  data fault, sampled together with mem_ack.
- fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  out  1 each  one-hot stage enables.
- mem_req  out  1  data memory request.
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
- busy  out  1  FSM is not in IDLE or HALT.
- halted  out  1  FSM is in HALT.
- cycle_cnt  out  CNT_W  busy cycles.
- instr_cnt  out  CNT_W  retired instructions.
- step  in  1  present only with SEQ_STEP_EN.

## Operation

- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Each stage enable is high only in its own state.
- IDLE: start -> FETCH.
- FETCH:
  - imem_error -> stat=ADR, HALT.
  - Otherwise !instr_valid -> stat=INS, HALT.
  - Otherwise icode==0 (halt) -> stat=HLT, HALT.
  - Otherwise -> DECODE.
  - imem_error has priority over INS; INS has priority over HLT.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY:
  - Memory icodes are 4, 5, 8, 9, A and B (the icode is latched at the end of FETCH). For these, mem_req is high from MEMORY entry until the cycle mem_ack is seen.
  - mem_ack with dmem_error -> stat=ADR, HALT.
  - mem_ack without dmem_error -> WRITEBACK.
  - No ack after MEM_TIMEOUT cycles in MEMORY -> stat=ADR, HALT, mem_req dropped.
  - Non-memory icodes: one cycle, mem_req stays 0.
- WRITEBACK -> PCUPD. PCUPD -> FETCH and increments instr_cnt.
- HALT: stage enables and mem_req are 0. start clears stat to AOK, clears both counters, and goes to FETCH.
- Counters:
  - cycle_cnt increments each cycle busy=1.
  - Both counters saturate at all-ones and never wrap.
- A mem_ack outside MEMORY, or for a non-memory icode, is ignored.

## Timing

- Reset values: state IDLE, all enables 0, mem_req 0, stat AOK, busy 0, halted 0, both counters 0. Reset asserted mid-instruction (including while mem_req is high) clears everything immediately; no partial retire.
- Latency:
  - Non-memory instruction: 6 cycles, FETCH through PCUPD.
  - Memory instruction: 5 + N cycles, where N ≥ 1 is the number of MEMORY cycles up to and including the mem_ack cycle.
- start is sampled only in IDLE or HALT and ignored elsewhere. A start in the same cycle as a fault transition is ignored.
- stat, halted and busy are registered and change on the edge that enters HALT.
- Timeout counter clears on MEMORY entry. MEM_TIMEOUT=1 allows exactly one MEMORY cycle.
- mem_ack and timeout expiry in the same cycle: the ack wins.

## Configuration

- SEQ_STEP_EN defined:
  - The step port exists.
  - PCUPD goes to IDLE instead of FETCH, and busy drops.
  - In IDLE, step or start -> FETCH.
  - One instruction runs per step pulse.
- SEQ_STEP_EN undefined:
  - No step port.
  - PCUPD -> FETCH and execution is continuous.

## Test plan

- Reset, start, nop (icode 1) with instr_valid=1: fetch_en…pc_en each high for exactly 1 cycle in order. instr_cnt=1 and cycle_cnt=6 after PCUPD.
- mrmovq (icode 5), mem_ack on the 3rd MEMORY cycle: mem_req high for 3 cycles, WRITEBACK follows, instruction takes 8 cycles.
- rmmovq (icode 4), no ack, MEM_TIMEOUT=4: after 4 MEMORY cycles stat=2, halted=1, mem_req=0, instr_cnt unchanged.
- FETCH with imem_error=1 and instr_valid=0: stat=2 (ADR, not INS). Then start: stat=0, counters 0, FETCH.
- icode 0 after two nops: stat=1, halted=1, instr_cnt=2. rst_n pulled low while in MEMORY of a popq: all outputs return to reset values asynchronously.
- With SEQ_STEP_EN: two step pulses 10 cycles apart -> instr_cnt=2 and busy=0 between them.
